// File: rtl/chacha_pkg.sv
// Shared types, constants and helpers for the ChaCha streaming core.
package chacha_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned BLOCK_W      = 512;
  localparam int unsigned ROUNDS_W     = 5;
  // Wide enough for 20 rounds at one quarter-round per cycle (80 steps).
  localparam int unsigned ROUND_STEP_W = 7;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [15:0]      state_t;
  typedef logic [3:0]        idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_e;

  localparam word_t [3:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  // [quarter-round][a,b,c,d] word indices.
  localparam idx_t [0:3][0:3] COL_IDX = {
    4'd0, 4'd4, 4'd8,  4'd12,
    4'd1, 4'd5, 4'd9,  4'd13,
    4'd2, 4'd6, 4'd10, 4'd14,
    4'd3, 4'd7, 4'd11, 4'd15
  };

  localparam idx_t [0:3][0:3] DIAG_IDX = {
    4'd0, 4'd5, 4'd10, 4'd15,
    4'd1, 4'd6, 4'd11, 4'd12,
    4'd2, 4'd7, 4'd8,  4'd13,
    4'd3, 4'd4, 4'd9,  4'd14
  };

  function automatic word_t bswap32(input word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round.
module chacha_qr
  import chacha_pkg::*;
(
  input  word_t a_i,
  input  word_t b_i,
  input  word_t c_i,
  input  word_t d_i,
  output word_t a_o,
  output word_t b_o,
  output word_t c_o,
  output word_t d_o
);

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  word_t a1, b1, c1, d1;

  always_comb begin
    a1  = a_i + b_i;
    d1  = rotl(d_i ^ a1, 16);
    c1  = c_i + d1;
    b1  = rotl(b_i ^ c1, 12);
    a_o = a1 + b1;
    d_o = rotl(d1 ^ a_o, 8);
    c_o = c1 + d_o;
    b_o = rotl(b1 ^ c_o, 7);
  end

endmodule

// File: rtl/chacha_stream_core.sv
// ChaCha block engine: configurable rounds and quarter-round parallelism,
// keystream XORed into a valid/ready stream with an auto-incrementing counter.
module chacha_stream_core
  import chacha_pkg::*;
#(
  parameter int unsigned QR_PAR     = 4,
  parameter int unsigned MAX_ROUNDS = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [255:0]        key,
  input  logic [95:0]         nonce,
  input  logic [31:0]         ctr_init,
  input  logic [ROUNDS_W-1:0] rounds,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BLOCK_W-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLOCK_W-1:0]  out_data,
  output logic                cfg_error,
  output logic                ctr_exhausted,
  output logic                busy
);

  if (QR_PAR != 1 && QR_PAR != 2 && QR_PAR != 4) begin : g_bad_qr_par
    $error("chacha_stream_core: QR_PAR must be 1, 2 or 4");
  end
  if (MAX_ROUNDS < 2 || MAX_ROUNDS > 20 || (MAX_ROUNDS % 2) != 0) begin : g_bad_max_rounds
    $error("chacha_stream_core: MAX_ROUNDS must be even, 2..20");
  end

  localparam int unsigned LOG_PAR = $clog2(QR_PAR);

  state_e                    state_q;
  logic [ROUND_STEP_W-1:0]   step_q;
  logic [ROUND_STEP_W-1:0]   last_step;
  logic [255:0]              key_q;
  logic [95:0]               nonce_q;
  word_t                     ctr_q;
  logic [ROUNDS_W-1:0]       rounds_q;
  logic                      configured_q;
  logic                      cfg_error_q;
  logic                      ctr_exhausted_q;
  logic                      out_valid_q;
  logic [BLOCK_W-1:0]        out_data_q;
  logic [BLOCK_W-1:0]        data_q;
  state_t                    work_q;
  state_t                    work_d;
  state_t                    init_st;
  logic [BLOCK_W-1:0]        keystream;
  logic                      rounds_bad;
  logic                      accept;

  logic [2:0] qsel [QR_PAR];
  idx_t       qidx [QR_PAR][4];
  word_t      qa_o [QR_PAR];
  word_t      qb_o [QR_PAR];
  word_t      qc_o [QR_PAR];
  word_t      qd_o [QR_PAR];

  assign rounds_bad = rounds[0] || (rounds == '0) || (32'(rounds) > MAX_ROUNDS);
  assign in_ready   = (state_q == IDLE) && configured_q && !cfg_error_q &&
                      !ctr_exhausted_q && !init;
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != IDLE);
  assign last_step  = ROUND_STEP_W'((32'(rounds_q) << (2 - LOG_PAR)) - 32'd1);

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign cfg_error     = cfg_error_q;
  assign ctr_exhausted = ctr_exhausted_q;

  // Initial state: key and nonce bytes packed little-endian into words.
  always_comb begin
    init_st = '0;
    for (int i = 0; i < 4; i++) init_st[i] = SIGMA[i];
    for (int i = 0; i < 8; i++) init_st[4+i] = bswap32(key_q[255-32*i -: 32]);
    init_st[12] = ctr_q;
    for (int i = 0; i < 3; i++) init_st[13+i] = bswap32(nonce_q[95-32*i -: 32]);
  end

  always_comb begin
    keystream = '0;
    for (int i = 0; i < 16; i++) keystream[511-32*i -: 32] = bswap32(work_q[i] + init_st[i]);
  end

  // A cycle's quarter-rounds never straddle the column/diagonal boundary.
  always_comb begin
    for (int j = 0; j < int'(QR_PAR); j++) begin
      qsel[j] = 3'(32'(step_q) * QR_PAR + 32'(j));
      for (int p = 0; p < 4; p++) begin
        qidx[j][p] = qsel[j][2] ? DIAG_IDX[qsel[j][1:0]][p] : COL_IDX[qsel[j][1:0]][p];
      end
    end
  end

  for (genvar j = 0; j < int'(QR_PAR); j++) begin : g_qr
    chacha_qr u_qr (
      .a_i (work_q[qidx[j][0]]),
      .b_i (work_q[qidx[j][1]]),
      .c_i (work_q[qidx[j][2]]),
      .d_i (work_q[qidx[j][3]]),
      .a_o (qa_o[j]),
      .b_o (qb_o[j]),
      .c_o (qc_o[j]),
      .d_o (qd_o[j])
    );
  end

  always_comb begin
    work_d = work_q;
    for (int j = 0; j < int'(QR_PAR); j++) begin
      work_d[qidx[j][0]] = qa_o[j];
      work_d[qidx[j][1]] = qb_o[j];
      work_d[qidx[j][2]] = qc_o[j];
      work_d[qidx[j][3]] = qd_o[j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      step_q          <= '0;
      key_q           <= '0;
      nonce_q         <= '0;
      ctr_q           <= '0;
      rounds_q        <= '0;
      configured_q    <= 1'b0;
      cfg_error_q     <= 1'b0;
      ctr_exhausted_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      data_q          <= '0;
      work_q          <= '0;
    end else if (init) begin
      key_q           <= key;
      nonce_q         <= nonce;
      ctr_q           <= ctr_init;
      rounds_q        <= rounds;
      cfg_error_q     <= rounds_bad;
      configured_q    <= !rounds_bad;
      ctr_exhausted_q <= 1'b0;
      out_valid_q     <= 1'b0;
      state_q         <= IDLE;
      step_q          <= '0;
    end else begin
      if (out_ready) out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            work_q  <= init_st;
            data_q  <= in_data;
            step_q  <= '0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          work_q <= work_d;
          step_q <= step_q + ROUND_STEP_W'(1);
          if (step_q == last_step) state_q <= FINAL;
        end
        FINAL: begin
          // Output register free or being drained this cycle.
          if (!out_valid_q || out_ready) begin
            out_data_q  <= data_q ^ keystream;
            out_valid_q <= 1'b1;
            ctr_q       <= ctr_q + 32'd1;
            if (ctr_q == 32'hFFFF_FFFF) ctr_exhausted_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_stream_core.sv
// Bench for chacha_stream_core: three instances (QR_PAR 4/2/1) against a
// loop-based ChaCha reference model, plus directed handshake/corner sequences.
module tb_chacha_stream_core;

  logic         clk = 1'b0;
  logic         reset, init, in_valid, out_ready;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr_init;
  logic [4:0]   rounds;
  logic [511:0] in_data;

  logic         rdy [3];
  logic         ov [3];
  logic         cerr [3];
  logic         cexh [3];
  logic         bsy [3];
  logic [511:0] od [3];

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] m_key;
  logic [95:0]  m_nonce;
  logic [31:0]  m_ctr;
  int           m_rounds;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    chacha_stream_core #(
      .QR_PAR     ((g == 0) ? 4 : (g == 1) ? 2 : 1),
      .MAX_ROUNDS (20)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .init          (init),
      .key           (key),
      .nonce         (nonce),
      .ctr_init      (ctr_init),
      .rounds        (rounds),
      .in_valid      (in_valid),
      .in_ready      (rdy[g]),
      .in_data       (in_data),
      .out_valid     (ov[g]),
      .out_ready     (out_ready),
      .out_data      (od[g]),
      .cfg_error     (cerr[g]),
      .ctr_exhausted (cexh[g]),
      .busy          (bsy[g])
    );
  end

  function automatic int par_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 2 : 1;
  endfunction

  function automatic int unsigned rotl(input int unsigned v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Straight RFC 8439 block function: byte-oriented state load and serialisation.
  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c, input int r,
                                             input logic [511:0] d);
    int unsigned s [16];
    int unsigned x [16];
    int          tab [8][4];
    int unsigned w;
    int          ia, ib, ic, id;
    logic [511:0] res;
    tab = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
            '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int wi = 0; wi < 8; wi++) begin
      s[4+wi] = 0;
      for (int b = 0; b < 4; b++) s[4+wi] |= 32'(k[255-8*(4*wi+b) -: 8]) << (8*b);
    end
    s[12] = c;
    for (int wi = 0; wi < 3; wi++) begin
      s[13+wi] = 0;
      for (int b = 0; b < 4; b++) s[13+wi] |= 32'(n[95-8*(4*wi+b) -: 8]) << (8*b);
    end
    x = s;
    for (int dr = 0; dr < r / 2; dr++) begin
      for (int q = 0; q < 8; q++) begin
        ia = tab[q][0]; ib = tab[q][1]; ic = tab[q][2]; id = tab[q][3];
        x[ia] += x[ib]; x[id] = rotl(x[id] ^ x[ia], 16);
        x[ic] += x[id]; x[ib] = rotl(x[ib] ^ x[ic], 12);
        x[ia] += x[ib]; x[id] = rotl(x[id] ^ x[ia], 8);
        x[ic] += x[id]; x[ib] = rotl(x[ib] ^ x[ic], 7);
      end
    end
    res = '0;
    for (int nb = 0; nb < 64; nb++) begin
      w = x[nb/4] + s[nb/4];
      res[511-8*nb -: 8] = d[511-8*nb -: 8] ^ 8'(w >> (8*(nb % 4)));
    end
    return res;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_init(input logic [255:0] k, input logic [95:0] n,
                         input logic [31:0] c, input logic [4:0] r);
    @(negedge clk);
    key = k; nonce = n; ctr_init = c; rounds = r; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    m_key = k; m_nonce = n; m_ctr = c; m_rounds = int'(r);
  endtask

  // One block through all three instances together, out_ready held low until all report.
  task automatic run_all(input logic [511:0] d, input logic [127:0] exp_hi,
                         input bit use_hi, input string nm);
    logic [511:0] exp;
    int           lat [3];
    exp = ref_block(m_key, m_nonce, m_ctr, m_rounds, d);
    out_ready = 1'b0;
    @(negedge clk);
    in_data = d; in_valid = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) chkb($sformatf("%s in_ready[%0d]", nm, g), rdy[g], 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = '{0, 0, 0};
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) if (lat[g] == 0 && ov[g]) lat[g] = cyc;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    for (int g = 0; g < 3; g++) begin
      chki($sformatf("%s latency[%0d]", nm, g), lat[g], m_rounds * 4 / par_of(g) + 1);
      chk($sformatf("%s data[%0d]", nm, g), od[g], exp);
      if (use_hi) chk($sformatf("%s hi128[%0d]", nm, g), {384'h0, od[g][511:384]}, {384'h0, exp_hi});
    end
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    m_ctr = m_ctr + 32'd1;
  endtask

  task automatic send0(input logic [511:0] d, input string nm);
    @(negedge clk);
    in_data = d; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 200 && !rdy[0]; i++) begin
      @(negedge clk);
      #1;
    end
    chkb({nm, " accept"}, rdy[0], 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_ov0(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1 seen = ov[0];
    end
    chkb({nm, " out_valid"}, seen, 1'b1);
  endtask

  typedef struct {
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic [4:0]   rounds;
    int           nblk;
    bit           has_hi;
    logic [127:0] hi0;
    logic [127:0] hi1;
  } vec_t;

  initial begin
    vec_t         vt [4];
    logic [511:0] da, db, ea, eb;
    logic [4:0]   bad_r [3];
    bit           flag;

    reset = 1'b1; init = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    key = '0; nonce = '0; ctr_init = '0; rounds = '0; in_data = '0;
    m_key = '0; m_nonce = '0; m_ctr = '0; m_rounds = 0;

    vt[0] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              96'h000000090000004a00000000, 32'd1, 5'd20, 1, 1'b1,
              128'h10f1e7e4d13b5915500fdd1fa32071c4, 128'h0};
    vt[1] = '{256'h0, 96'h0, 32'd0, 5'd20, 2, 1'b1,
              128'h76b8e0ada0f13d90405d6ae55386bd28, 128'h9f07e7be5551387a98ba977c732d080d};
    vt[2] = '{rand256(), 96'(rand256()), $urandom, 5'd8,  2, 1'b0, 128'h0, 128'h0};
    vt[3] = '{rand256(), 96'(rand256()), $urandom, 5'd12, 2, 1'b0, 128'h0, 128'h0};

    repeat (3) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chkb($sformatf("reset in_ready[%0d]", g), rdy[g], 1'b0);
      chkb($sformatf("reset out_valid[%0d]", g), ov[g], 1'b0);
      chk($sformatf("reset out_data[%0d]", g), od[g], '0);
      chkb($sformatf("reset cfg_error[%0d]", g), cerr[g], 1'b0);
      chkb($sformatf("reset ctr_exhausted[%0d]", g), cexh[g], 1'b0);
      chkb($sformatf("reset busy[%0d]", g), bsy[g], 1'b0);
    end
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_init(vt[i].key, vt[i].nonce, vt[i].ctr, vt[i].rounds);
      for (int b = 0; b < vt[i].nblk; b++) begin
        run_all(vt[i].has_hi ? 512'h0 : rand512(), (b == 0) ? vt[i].hi0 : vt[i].hi1,
                vt[i].has_hi, $sformatf("vec%0d blk%0d", i, b));
      end
    end

    for (int i = 0; i < 5; i++) begin
      do_init(rand256(), 96'(rand256()), $urandom, 5'(2 * $urandom_range(1, 10)));
      run_all(rand512(), 128'h0, 1'b0, $sformatf("rnd%0d a", i));
      run_all(rand512(), 128'h0, 1'b0, $sformatf("rnd%0d b", i));
    end

    // Backpressure: second block parks in FINAL behind an unconsumed first block.
    do_init(rand256(), 96'(rand256()), $urandom, 5'd20);
    out_ready = 1'b0;
    da = rand512(); db = rand512();
    ea = ref_block(m_key, m_nonce, m_ctr, m_rounds, da);
    eb = ref_block(m_key, m_nonce, m_ctr + 32'd1, m_rounds, db);
    send0(da, "bp A");
    wait_ov0("bp A");
    send0(db, "bp B");
    flag = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (!ov[0] || od[0] !== ea) flag = 1'b1;
    end
    chkb("bp hold stable", flag, 1'b0);
    chk("bp hold data", od[0], ea);
    chkb("bp stalled busy", bsy[0], 1'b1);
    chkb("bp stalled in_ready", rdy[0], 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chkb("bp B valid", ov[0], 1'b1);
    chk("bp B data", od[0], eb);
    chkb("bp drained busy", bsy[0], 1'b0);
    @(posedge clk);
    #1 chkb("bp cleared", ov[0], 1'b0);
    @(negedge clk) out_ready = 1'b0;

    // Counter wrap.
    do_init(rand256(), 96'(rand256()), 32'hFFFF_FFFF, 5'd20);
    out_ready = 1'b1;
    da = rand512();
    ea = ref_block(m_key, m_nonce, m_ctr, m_rounds, da);
    send0(da, "wrap");
    wait_ov0("wrap");
    chk("wrap data", od[0], ea);
    chkb("wrap ctr_exhausted", cexh[0], 1'b1);
    @(negedge clk) in_valid = 1'b1;
    #1 chkb("wrap in_ready", rdy[0], 1'b0);
    repeat (3) @(negedge clk);
    chkb("wrap no accept", bsy[0], 1'b0);
    in_valid = 1'b0;
    do_init(m_key, m_nonce, 32'd0, 5'd20);
    #1;
    chkb("wrap reinit exhausted", cexh[0], 1'b0);
    chkb("wrap reinit in_ready", rdy[0], 1'b1);
    out_ready = 1'b0;
    run_all(rand512(), 128'h0, 1'b0, "wrap reinit");

    // Illegal round counts.
    bad_r = '{5'd7, 5'd0, 5'd22};
    for (int i = 0; i < 3; i++) begin
      do_init(rand256(), 96'(rand256()), $urandom, bad_r[i]);
      in_valid = 1'b1;
      #1;
      chkb($sformatf("cfg r=%0d cfg_error", bad_r[i]), cerr[0], 1'b1);
      chkb($sformatf("cfg r=%0d in_ready", bad_r[i]), rdy[0], 1'b0);
      @(negedge clk);
      chkb($sformatf("cfg r=%0d idle", bad_r[i]), bsy[0], 1'b0);
      in_valid = 1'b0;
    end
    do_init(rand256(), 96'(rand256()), $urandom, 5'd20);
    #1 chkb("cfg legal clears", cerr[0], 1'b0);

    // Init wins over a simultaneous in_valid.
    @(negedge clk);
    in_valid = 1'b1; init = 1'b1;
    #1 chkb("init vs valid in_ready", rdy[0], 1'b0);
    @(posedge clk);
    #1 chkb("init vs valid no accept", bsy[0], 1'b0);
    @(negedge clk);
    in_valid = 1'b0; init = 1'b0;

    // Init aborts a block mid-ROUND.
    do_init(rand256(), 96'(rand256()), $urandom, 5'd20);
    out_ready = 1'b1;
    da = rand512();
    send0(da, "abort");
    repeat (5) @(posedge clk);
    do_init(m_key, m_nonce, m_ctr, 5'd20);
    chkb("abort out_valid", ov[0], 1'b0);
    chkb("abort busy", bsy[0], 1'b0);
    flag = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0]) flag = 1'b1;
    end
    chkb("abort no stale", flag, 1'b0);
    ea = ref_block(m_key, m_nonce, m_ctr, m_rounds, da);
    send0(da, "abort resend");
    wait_ov0("abort resend");
    chk("abort resend data", od[0], ea);

    // Reset while a block stalls in FINAL.
    do_init(rand256(), 96'(rand256()), $urandom, 5'd20);
    out_ready = 1'b0;
    send0(rand512(), "rst A");
    wait_ov0("rst A");
    send0(rand512(), "rst B");
    repeat (25) @(negedge clk);
    chkb("rst pre busy", bsy[0], 1'b1);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chkb("rst out_valid", ov[0], 1'b0);
    chkb("rst busy", bsy[0], 1'b0);
    chk("rst out_data", od[0], '0);
    chkb("rst in_ready", rdy[0], 1'b0);
    out_ready = 1'b1;
    flag = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov[0]) flag = 1'b1;
    end
    chkb("rst no stale", flag, 1'b0);
    do_init(rand256(), 96'(rand256()), $urandom, 5'd12);
    run_all(rand512(), 128'h0, 1'b0, "post reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/chacha_stream_core.md
Name: chacha_stream_core

Overview:
Parametrised ChaCha block-function engine with a streaming XOR datapath. It sits behind the chacha register front-end, in place of the fixed single-block core. It holds key, nonce and a block counter loaded by an init pulse. For each accepted 512-bit input block it runs a programmable number of rounds at a configurable quarter-round parallelism, XORs the resulting keystream into the data, and auto-increments the counter. Input and output use valid/ready handshakes with full backpressure.

Parameters:
QR_PAR, 4, quarter-rounds per cycle; legal values 1, 2, 4; any other value is an elaboration error.
MAX_ROUNDS, 20, largest accepted round count; even, 2 to 20.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
init  in  1  one-cycle pulse: latch key/nonce/ctr_init/rounds, abort any block in flight.
key  in  256  key; byte 0 at [255:248].
nonce  in  96  nonce; byte 0 at [95:88].
ctr_init  in  32  initial block counter (state word 12).
rounds  in  5  round count, sampled on init.
in_valid  in  1  in_data valid.
in_ready  out  1  block accepted when in_valid && in_ready.
in_data  in  512  plaintext/ciphertext; byte 0 at [511:504].
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts.
out_data  out  512  in_data XOR keystream, same byte order.
cfg_error  out  1  sticky: last init carried an illegal rounds value.
ctr_exhausted  out  1  sticky: a block was produced with counter 0xFFFFFFFF.
busy  out  1  state != IDLE.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, cfg_error=0, ctr_exhausted=0, busy=0, configured=0, state=IDLE.
- Init cycle: latches key, nonce, ctr_init and rounds; clears cfg_error, ctr_exhausted and out_valid; forces state to IDLE.
- Init with rounds that is odd, 0 or greater than MAX_ROUNDS sets cfg_error; configured stays 0.
- Init wins over a simultaneous in_valid: in_ready is 0 in any cycle where init=1.
- in_ready = (state==IDLE) && configured && !cfg_error && !ctr_exhausted && !init.
- State words are loaded little-endian from bytes: sigma constants 61707865 3320646e 79622d32 6b206574, key words 4..11, counter word 12, nonce words 13..15.
- FSM states:
  - IDLE: on accept, load the working state and the copy of in_data, step=0, go to ROUND.
  - ROUND: each cycle applies QR_PAR quarter-rounds. The per-double-round QR order is col0..col3, then diag0..diag3; cols are (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15); diags are (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14). After N = rounds*4/QR_PAR cycles go to FINAL.
  - FINAL: compute (working + initial state) mod 2^32 per word, serialise LE into keystream, XOR with in_data. If out_valid=0 or out_ready=1: register out_data, set out_valid, increment the counter, go to IDLE. Otherwise stall in FINAL.
- Latency: accept at edge k gives out_valid high after edge k+N+1. Example: 20 rounds with QR_PAR=4 is 21 cycles; with QR_PAR=1 it is 81 cycles.
- Output: out_valid and out_data hold stable until out_ready. out_valid clears on out_ready unless FINAL loads a new block in the same cycle.
- Counter wrap: a block with counter 0xFFFFFFFF is produced normally; the counter wraps to 0 and ctr_exhausted sets. No further accepts until init.
- Reset mid-operation: all state returns to reset values; key registers need not clear, but configured=0.

Decomposition:
- chacha_pkg holds: SIGMA constants, the column/diagonal index tables, the FSM state encoding (IDLE/ROUND/FINAL), ROUND_STEP_W, and a byte-swap function.
- Sub-module chacha_qr: purely combinational quarter-round (a, b, c, d in and out, 32-bit each), instantiated QR_PAR times.

Test Plan:
- RFC 8439 section 2.3.2: key 000102..1f, nonce 000000090000004a00000000, ctr_init 1, rounds 20, in_data 0. Required: out_data[511:384]=128'h10f1e7e4d13b5915500fdd1fa32071c4; out_valid exactly 21 cycles after accept with QR_PAR=4, 41 with QR_PAR=2, 81 with QR_PAR=1.
- RFC 7539 A.1 vector 1: key 0, nonce 0, ctr 0, rounds 20, data 0. Required: out_data[511:384]=128'h76b8e0ada0f13d90405d6ae55386bd28. A second block, with the counter auto-incremented to 1, must give out_data[511:384]=128'h9f07e7be5551387a98ba977c732d080d.
- Backpressure: out_ready held 0 for 30 cycles after the first block. Required: out_data stable; a second block stalls in FINAL; in_ready=0; both blocks delivered in order when out_ready=1.
- ctr_init=0xFFFFFFFF: one block is produced, then ctr_exhausted=1 and in_ready=0. A following init with ctr_init 0 clears ctr_exhausted and restores in_ready.
- Init with rounds=7, 0 and 22 each set cfg_error=1 and hold in_ready=0. rounds=8 and 12 must match a reference model.
- Init asserted during ROUND, and reset asserted during FINAL: out_valid=0 next cycle, busy=0, and no stale output afterwards.
